// File: rtl/instr_encoder.sv
// Packs decoded RV32 fields into I-type or S-type instruction words behind a small output FIFO.
// Define IMM_RANGE_CHECK_EN to reject immediates outside -2048..2047 (err pulse + err_cnt).
module instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             immsrc,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CTR_ONE = CNT_W'(1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("instr_encoder: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      word;
    logic             legal;
    logic             accept;
    logic             push;
    logic             pop;

    always_comb begin
        word = '0;
        if (immsrc) begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        end else begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    // Legal 12-bit signed range means bits 31..11 are a pure sign extension.
    assign legal = (imm[31:11] == '0) || (imm[31:11] == '1);
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:12];
    assign legal = 1'b1;
`endif

    // in_ready depends only on rst and occupancy, so a pop cannot free a slot in the same cycle.
    assign in_ready  = !rst && (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign instr     = out_valid ? mem[rd_ptr] : '0;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_cnt <= '0;
        end else if (push) begin
            enc_cnt <= enc_cnt + CTR_ONE;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal) begin
                err_cnt <= err_cnt + CTR_ONE;
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomized fields checked against an arithmetic encoding model.
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             immsrc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit [31:0]        exp_q[$];
    logic [CNT_W-1:0] m_enc = '0;
    logic [CNT_W-1:0] m_err = '0;
    bit               err_exp = 1'b0;
    bit               rand_rdy = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .opcode(opcode), .funct3(funct3), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .err(err),
        .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    function automatic bit is_legal(logic [31:0] v);
        int s;
        s = int'($signed(v));
`ifdef IMM_RANGE_CHECK_EN
        return (s >= -2048) && (s <= 2047);
`else
        return (s == s);
`endif
    endfunction

    function automatic bit [31:0] model(bit src, bit [6:0] op, bit [2:0] f3, bit [4:0] d,
                                        bit [4:0] s1, bit [4:0] s2, bit [31:0] im);
        bit [31:0] w;
        if (!src)
            w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
        else
            w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                | ((im & 32'h1F) << 7) | 32'(op);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard/monitor: compares DUT state before each edge, then books the upcoming edge's effects.
    always @(negedge clk) begin
        int sz;
        bit acc;
        bit nxt_err;
        if (rst) begin
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
            exp_q.delete();
            m_enc   = '0;
            m_err   = '0;
            err_exp = 1'b0;
        end else begin
            sz = exp_q.size();
            nxt_err = 1'b0;
            chk("err", 32'(err), 32'(err_exp));
            chk("enc_cnt", 32'(enc_cnt), 32'(m_enc));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("out_valid", 32'(out_valid), 32'(sz != 0));
            chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
            if (sz > 0) chk("instr", instr, exp_q[0]);
            acc = in_valid && (sz < DEPTH);
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
            if (acc) begin
                if (is_legal(imm)) begin
                    exp_q.push_back(model(immsrc, opcode, funct3, rd, rs1, rs2, imm));
                    m_enc = m_enc + 1'b1;
                end else begin
                    nxt_err = 1'b1;
                    m_err = m_err + 1'b1;
                end
            end
            err_exp = nxt_err;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit src, input bit [6:0] op, input bit [2:0] f3, input bit [4:0] d,
                        input bit [4:0] s1, input bit [4:0] s2, input bit [31:0] im);
        bit acc;
        immsrc = src; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                in_valid = 1'b0;
                imm = $urandom;
                rd = 5'($urandom);
                rs2 = 5'($urandom);
                return;
            end
        end
        errors++;
        $display("FAIL send_timeout: got no accept within 500 cycles, required accept");
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        bit [31:0] im;
        bit [31:0] edges [4];
        edges[0] = 32'hFFFF_F800; edges[1] = 32'h0000_07FF;
        edges[2] = 32'h0000_0800; edges[3] = 32'hFFFF_F7FF;

        rst = 1'b1; in_valid = 1'b0; immsrc = 1'b0; opcode = '0; funct3 = '0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        step();

        // lw x5, -4(x2)
        out_ready = 1'b1;
        send(1'b0, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("lw_out_valid", 32'(out_valid), 32'd1);
        chk("lw_instr", instr, 32'hFFC12283);
        chk("lw_enc_cnt", 32'(enc_cnt), 32'd1);
        step();

        // sw x6, 8(x2) with a junk rd
        send(1'b1, 7'b0100011, 3'b010, 5'd31, 5'd2, 5'd6, 32'd8);
        @(negedge clk);
        chk("sw_instr", instr, 32'h00612423);
        step();
        repeat (2) step();

        // Fill, stall, then release across pointer wrap
        out_ready = 1'b0;
        send(1'b0, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1);
        send(1'b0, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        fork
            send(1'b0, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3);
            begin
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        repeat (4) step();

        // imm = 2048
        send(1'b0, 7'b0010011, 3'b000, 5'd3, 5'd4, 5'd0, 32'd2048);
        @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_err_cnt", 32'(err_cnt), 32'd1);
        chk("oor_out_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("oor_err_clear", 32'(err), 32'd0);
`else
        chk("trunc_imm", {20'd0, instr[31:20]}, 32'h800);
        chk("trunc_err", 32'(err), 32'd0);
`endif
        step();
        repeat (2) step();

        // One entry buffered, simultaneous push and pop
        out_ready = 1'b0;
        send(1'b0, 7'b0010011, 3'b100, 5'd7, 5'd8, 5'd0, 32'd100);
        out_ready = 1'b1;
        send(1'b1, 7'b0100011, 3'b001, 5'd0, 5'd9, 5'd10, 32'hFFFF_FFF9);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_out_valid", 32'(out_valid), 32'd1);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        chk("pp_instr", instr, model(1'b1, 7'b0100011, 3'b001, 5'd0, 5'd9, 5'd10, 32'hFFFF_FFF9));
        step();
        out_ready = 1'b1;
        repeat (2) step();

        // Reset with two entries buffered
        out_ready = 1'b0;
        send(1'b0, 7'b0010011, 3'b000, 5'd11, 5'd12, 5'd0, 32'd5);
        send(1'b0, 7'b0010011, 3'b000, 5'd13, 5'd14, 5'd0, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        step();
        out_ready = 1'b1;
        send(1'b0, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("post_rst_instr", instr, 32'hFFC12283);
        step();

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: im = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: im = edges[$urandom_range(0, 3)];
                2: im = $urandom;
                default: im = 32'($urandom_range(0, 63));
            endcase
            send(1'($urandom_range(0, 1)), 7'($urandom), 3'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), im);
            if ($urandom_range(0, 4) == 0) step();
        end

        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        step();
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate extender: packs decoded fields (opcode, funct3, rd, rs1, rs2, signed 32-bit immediate) into a 32-bit RV32 I-type or S-type instruction word.
- Sits between the test-program generator / boot loader and instruction memory.
- Valid/ready on both sides, with a small output FIFO so the memory writer can stall without losing instructions.
- Range-checks immediates and counts encoded and rejected instructions.

Parameters:
- DEPTH, 2, output FIFO entries; power of 2, >= 2.
- CNT_W, 16, width of the encoded-instruction and error counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input fields valid.
- in_ready  output  1  block can accept input.
- immsrc  input  1  0 = I-type (ALU/load), 1 = S-type (store).
- opcode  input  7  instruction bits [6:0].
- funct3  input  3  instruction bits [14:12].
- rd  input  5  destination register; I-type only.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2; S-type only.
- imm  input  32  signed immediate.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- instr  output  32  encoded instruction at FIFO head.
- err  output  1  one-cycle pulse: input rejected.
- enc_cnt  output  CNT_W  instructions accepted into FIFO.
- err_cnt  output  CNT_W  inputs rejected.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - FIFO emptied: pointers = 0, count = 0.
  - out_valid = 0, instr = 0, err = 0, enc_cnt = 0, err_cnt = 0.
  - in_ready = 0 while rst is high; 1 from the first cycle after reset.
- Reset mid-operation discards all buffered entries; nothing is emitted afterwards.
- in_ready = (count < DEPTH). It is registered-state derived, with no combinational path from out_ready.
  - When full, a same-cycle pop does not allow a push.
- Accept: in_valid & in_ready at a clock edge.
- Encoding (combinational on inputs, registered into FIFO):
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - rd is ignored for S-type; rs2 is ignored for I-type.
- Range check: imm is legal iff imm[31:11] is all 0s or all 1s (-2048..2047).
- Legal accept:
  - Word is written at the write pointer; count increments.
  - enc_cnt increments.
- Illegal accept:
  - Nothing is written.
  - err = 1 for exactly the next cycle.
  - err_cnt increments.
  - The input is still consumed (handshake completes).
- Latency: a legal input accepted at edge N gives out_valid = 1 and instr valid after edge N when the FIFO was empty. There is no combinational bypass.
- Output:
  - out_valid = (count != 0); instr = mem[rd_ptr]. instr holds stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready: rd_ptr advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous legal push and pop (not full): count unchanged, both pointers advance.
- Simultaneous illegal push and pop: pop only.
- Counters wrap from 2^CNT_W-1 to 0 without saturating.
- Unknown values are never written into the FIFO.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: range check as above, with err/err_cnt active.
- Undefined:
  - Every accepted input is encoded using imm[11:0]; upper bits are silently truncated.
  - err is tied to 0; err_cnt is tied to 0.
  - enc_cnt counts all accepts.

Test Plan:
- Reset, then I-type lw: opcode=0000011, funct3=010, rd=5, rs1=2, imm=-4, out_ready=1.
  - Next cycle out_valid=1, instr=0xFFC12283.
  - enc_cnt=1.
- S-type sw: opcode=0100011, funct3=010, rs1=2, rs2=6, imm=8.
  - instr=0x00612423.
  - The rd input value has no effect.
- DEPTH=2, out_ready=0, push 3 back-to-back legal inputs.
  - in_ready=0 after the 2nd accept; 3rd held until a pop.
  - Output order preserved across pointer wrap.
- imm=2048 with IMM_RANGE_CHECK_EN defined:
  - err pulses 1 cycle, err_cnt=1, no out_valid.
  - With the macro undefined: instr[31:20]=0x800, err=0.
- FIFO holding 1 entry, simultaneous push+pop: count stays 1, new word is next out.
- Assert rst for 1 cycle with 2 entries buffered:
  - Next cycle out_valid=0, enc_cnt=0, err_cnt=0.
  - Subsequent push emits normally.
